// File: rtl/mem_req_stage_pkg.sv
// Shared widths, control-flow bit positions, load/store size codes and FSM encoding
// for the memory request stage.
package mem_req_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RD_WIDTH   = 5;

    localparam int CF_MEM_WRITE = 3;
    localparam int CF_MEM_READ  = 2;
    localparam int CF_MEM2REG   = 1;
    localparam int CF_WRITE_REG = 0;

    localparam logic [2:0] LS_B = 3'd0;
    localparam logic [2:0] LS_H = 3'd1;
    localparam logic [2:0] LS_W = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_ACC  = 3'b100
    } state_t;

    // Size is func3[1:0] so the unsigned loads (LBU/LHU) are covered too.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] idx);
        return ((size == LS_H[1:0]) && idx[0]) || ((size == LS_W[1:0]) && (idx != 2'b00));
    endfunction

endpackage

// File: rtl/mem_req_stage_if.sv
// Request bus between the memory stage and the data memory port.
interface mem_req_stage_if;
    import mem_req_stage_pkg::*;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_addr_ok;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_addr_ok);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    output mem_addr_ok);

endinterface

// File: rtl/mem_req_stage_ram_wdata_mask.sv
// Store-side lane steering: replicates byte/halfword data across the word and
// builds the byte strobe from the low address bits.
module ram_wdata_mask
    import mem_req_stage_pkg::*;
(
    input  logic [1:0]            addr_idx,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [2:0]            func3,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb
);

    always_comb begin
        wdata = data;
        wstrb = 4'b0000;
        case (func3)
            LS_B: begin
                wdata = {(DATA_WIDTH/8){data[7:0]}};
                wstrb = 4'b0001 << addr_idx;
            end
            LS_H: begin
                wdata = {(DATA_WIDTH/16){data[15:0]}};
                wstrb = 4'b0011 << {addr_idx[1], 1'b0};
            end
            LS_W:    wstrb = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_req_stage.sv
// Memory request pipeline stage: latches the EX result, issues one memory request
// per load/store and hands the entry to write-back. Optional: MISALIGN_TRAP_EN.
//
// state   | meaning
// IDLE    | no request outstanding (empty, or non-memory / trapped entry)
// REQ     | memory entry held, mem_req asserted until mem_addr_ok
// ACC     | request accepted, waiting for write-back to take the entry
module mem_req_stage
    import mem_req_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cancel,
    input  logic                  hold,

    input  logic                  valid_id,
    input  logic                  ready_go_id,
    output logic                  allow_in_ex,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [3:0]            control_flow_i,
    input  logic [RD_WIDTH-1:0]   rd_i,
    input  logic [2:0]            ins_func3_i,
    input  logic                  fence_type_i,

    mem_req_stage_if.master       mem,

    output logic                  valid_ex,
    output logic                  ready_go_ex,
    input  logic                  allow_in_wb,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [3:0]            control_flow_ex,
    output logic [RD_WIDTH-1:0]   rd_ex,
    output logic [2:0]            ins_func3_o,
    output logic                  fence_type_ex,
    output logic                  misalign_o
);

    state_t                state, state_nxt;
    logic                  valid;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [3:0]            control_flow;
    logic [RD_WIDTH-1:0]   rd;
    logic [2:0]            ins_func3;
    logic                  fence_type;

    logic                  handoff, load_en, in_mem, in_mis, go_req, cur_mis;
    logic                  mem_req_c, ready_go_c;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;

    assign handoff     = allow_in_wb && !hold;
    assign allow_in_ex = !valid || (ready_go_ex && handoff);
    assign load_en     = valid_id && ready_go_id && allow_in_ex;
    assign in_mem      = control_flow_i[CF_MEM_WRITE] | control_flow_i[CF_MEM_READ];
    // Next state looks at the entry being loaded so mem_req rises the cycle it becomes valid.
    assign go_req      = load_en && in_mem && !in_mis && !cancel;

`ifdef MISALIGN_TRAP_EN
    logic is_mem;
    assign is_mem  = control_flow[CF_MEM_WRITE] | control_flow[CF_MEM_READ];
    assign in_mis  = in_mem && is_misaligned(ins_func3_i[1:0], alu_result_i[1:0]);
    assign cur_mis = valid && is_mem && is_misaligned(ins_func3[1:0], alu_result[1:0]);
`else
    assign in_mis  = 1'b0;
    assign cur_mis = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid        <= 1'b0;
            alu_result   <= '0;
            rs2_data     <= '0;
            control_flow <= '0;
            rd           <= '0;
            ins_func3    <= '0;
            fence_type   <= 1'b0;
        end else begin
            if (cancel)
                valid <= 1'b0;
            else if (allow_in_ex)
                valid <= valid_id && ready_go_id;
            if (load_en) begin
                alu_result   <= alu_result_i;
                rs2_data     <= rs2_data_i;
                control_flow <= control_flow_i;
                rd           <= rd_i;
                ins_func3    <= ins_func3_i;
                fence_type   <= fence_type_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (go_req) state_nxt = ST_REQ;
            ST_REQ:  if (mem.mem_addr_ok)
                         state_nxt = !handoff ? ST_ACC : (go_req ? ST_REQ : ST_IDLE);
            ST_ACC:  if (handoff) state_nxt = go_req ? ST_REQ : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (cancel)
            state_nxt = ST_IDLE;
    end

    // Kept apart from next-state logic: allow_in_ex depends on ready_go_ex.
    always_comb begin
        mem_req_c  = 1'b0;
        ready_go_c = 1'b0;
        case (state)
            ST_IDLE: ready_go_c = valid;
            ST_REQ: begin
                mem_req_c  = !cancel;
                ready_go_c = mem.mem_addr_ok;
            end
            ST_ACC:  ready_go_c = 1'b1;
            default: ;
        endcase
    end

    ram_wdata_mask u_wdata_mask (
        .addr_idx (alu_result[1:0]),
        .data     (rs2_data),
        .func3    (ins_func3),
        .wdata    (wdata),
        .wstrb    (wstrb)
    );

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_we    = control_flow[CF_MEM_WRITE];
    assign mem.mem_addr  = {alu_result[DATA_WIDTH-1:2], 2'b00};
    assign mem.mem_wdata = wdata;
    assign mem.mem_wstrb = control_flow[CF_MEM_WRITE] ? wstrb : 4'b0000;

    assign ready_go_ex     = ready_go_c;
    assign valid_ex        = valid;
    assign mem_address_o   = alu_result;
    assign control_flow_ex = (valid && !cur_mis) ? control_flow : 4'b0000;
    assign rd_ex           = rd;
    assign ins_func3_o     = ins_func3;
    assign fence_type_ex   = fence_type;
    assign misalign_o      = cur_mis;

endmodule

// File: doc/mem_req_stage.md
MEM_REQ_STAGE -- requirements
Module: mem_req_stage

Interface
REQ-001 SHALL use `DATA_WIDTH, default 32, width of address, data and result buses (from include.v).
REQ-002 SHALL use `RD_WIDTH, default 5, width of destination register index (from include.v).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cancel  in  1  pipeline flush; hold  in  1  freeze the stage.
REQ-006 valid_id, ready_go_id  in  1 each  upstream handshake; allow_in_ex  out  1  stage can accept.
REQ-007 alu_result_i  in  DATA_WIDTH  address or ALU result; rs2_data_i  in  DATA_WIDTH  store data.
REQ-008 control_flow_i  in  4  control bits: [3] mem_write, [2] mem_read, [1] mem2reg, [0] write_reg.
REQ-009 rd_i  in  RD_WIDTH; ins_func3_i  in  3; fence_type_i  in  1  fence marker.
REQ-010 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  DATA_WIDTH; mem_wstrb  out  4.
REQ-011 mem_addr_ok  in  1  memory accepted the request this cycle.
REQ-012 valid_ex, ready_go_ex  out  1 each; allow_in_wb  in  1  downstream handshake.
REQ-013 mem_address_o  out  DATA_WIDTH; control_flow_ex  out  4; rd_ex  out  RD_WIDTH; ins_func3_o  out  3; fence_type_ex  out  1.
REQ-014 misalign_o  out  1  misaligned-access flag (see Configuration).

Function
REQ-015 Entry register SHALL load alu_result_i, rs2_data_i, control_flow_i, rd_i, ins_func3_i, fence_type_i when valid_id && ready_go_id && allow_in_ex.
REQ-016 valid SHALL load (valid_id && ready_go_id) whenever allow_in_ex=1; valid_ex = valid.
REQ-017 allow_in_ex SHALL be !valid || (ready_go_ex && allow_in_wb && !hold).
REQ-018 FSM states IDLE, REQ, ACC (one-hot); IDLE after reset.
REQ-019 IDLE: a valid entry with control_flow[3]|[2] set moves to REQ; non-memory entries stay in IDLE with ready_go_ex=1.
REQ-020 REQ: mem_req=1 combinationally, including the same cycle the entry becomes valid; addr, we, wdata, wstrb held stable until mem_addr_ok.
REQ-021 REQ with mem_addr_ok=1: ready_go_ex=1 that cycle; if allow_in_wb && !hold, hand off and go to IDLE (or remain REQ if a new memory entry loads), else go to ACC.
REQ-022 ACC: mem_req=0, ready_go_ex=1; leave to IDLE on hand-off.
REQ-023 A request SHALL never be issued twice: mem_req=0 in ACC.
REQ-024 cancel in REQ before mem_addr_ok: mem_req dropped the same cycle, valid cleared, next state IDLE.
REQ-025 cancel coincident with mem_addr_ok, or cancel in ACC: valid cleared, next state IDLE; the downstream stage also sees cancel and absorbs the response.
REQ-026 hold SHALL not suppress mem_req; it only blocks hand-off.
REQ-027 mem_addr = {alu_result[DATA_WIDTH-1:2], 2'b00}; mem_we = control_flow[3].
REQ-028 Store func3 0 (SB): mem_wstrb = 4'b0001 << addr[1:0], byte replicated x4.
REQ-029 Store func3 1 (SH): mem_wstrb = 4'b0011 << {addr[1],1'b0}, halfword replicated x2.
REQ-030 Store func3 2 (SW): mem_wstrb = 4'b1111, wdata = rs2; loads: mem_wstrb = 0.
REQ-031 Downstream outputs SHALL be the entry register; control_flow_ex = 0 when !valid.

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE, valid 0, all entry fields 0; mem_req, ready_go_ex, misalign_o 0; allow_in_ex 1 afterwards.
REQ-033 Reset during REQ SHALL drop mem_req on the next edge without waiting for mem_addr_ok.

Configuration
REQ-034 Macro MISALIGN_TRAP_EN: when defined, halfword access with addr[0]=1 or word access with addr[1:0]!=0 sets misalign_o=1, suppresses mem_req, and passes through with ready_go_ex=1 and control_flow_ex[3:0]=0.
REQ-035 Without MISALIGN_TRAP_EN: misalign_o tied 0; access issued with the low address bits ignored.

Structure
REQ-036 include.v SHALL hold DATA_WIDTH, RD_WIDTH, control_flow bit indices, func3 codes (LS_B/LS_H/LS_W) and the FSM state encodings.
REQ-037 Strobe/data alignment SHALL be the sub-module ram_wdata_mask (addr index, data, func3 -> wdata, wstrb), the store-side counterpart of ram_rdata_mask.

Verification
REQ-038 Store word 0x11223344 to 0x100, addr_ok same cycle -> mem_req=1, wstrb=1111, wdata=0x11223344, ready_go_ex same cycle.
REQ-039 SB 0xAB to 0x203 -> mem_addr=0x200, wstrb=1000, wdata=0xABABABAB.
REQ-040 Load with addr_ok delayed 3 cycles -> mem_req high 3 cycles, addr stable, ready_go_ex only in cycle 3, allow_in_ex=0 meanwhile.
REQ-041 addr_ok while allow_in_wb=0 for 2 cycles -> state ACC, mem_req=0, single request counted, hand-off when allow_in_wb=1.
REQ-042 cancel in REQ cycle 2 of a wait -> mem_req low that cycle, valid_ex=0 next cycle, state IDLE.
REQ-043 With MISALIGN_TRAP_EN, SW to 0x102 -> misalign_o=1, mem_req=0; without it -> mem_addr=0x100, wstrb=1111.
